// File: rtl/opamp_sar_ctrl_if.sv
// Bus between the SAR controller and its environment: conversion control,
// comparator input, DAC drive, result and an FSM state tap.
interface opamp_sar_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic             cmp_in;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [1:0]       fsm_state;

    modport master (
        output start, abort, cmp_in,
        input  dac_code, busy, done, result, fsm_state
    );

    modport slave (
        input  start, abort, cmp_in,
        output dac_code, busy, done, result, fsm_state
    );
endinterface

// File: rtl/opamp_sar_ctrl.sv
// Successive-approximation controller for an op-amp comparator and external
// R-2R DAC: MSB-first binary search, SETTLE cycles of DAC hold per decision.
module opamp_sar_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    opamp_sar_ctrl_if.slave   bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(SETTLE);
    localparam logic [WIDTH-1:0] MSB    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    RELOAD = CW'(SETTLE - 1);
    localparam logic [IW-1:0]    TOP    = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DECIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             cmp_meta;
    logic             cmp_s;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] code_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] trial;
    logic             launch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= bus.cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // DONE chains straight into a new conversion when start is still high,
    // so held-start conversions run back to back without an IDLE cycle.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (bus.start && !bus.abort) state_n = S_SETTLE;
            S_SETTLE: begin
                if (bus.abort)      state_n = S_IDLE;
                else if (cnt == '0) state_n = S_DECIDE;
            end
            S_DECIDE: begin
                if (bus.abort)          state_n = S_IDLE;
                else if (bit_idx == '0) state_n = S_DONE;
                else                    state_n = S_SETTLE;
            end
            S_DONE:   state_n = bus.start ? S_SETTLE : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state == S_SETTLE) || (state == S_DECIDE);
        bus.done      = (state == S_DONE);
        bus.fsm_state = state;
    end

    assign launch = (state_n == S_SETTLE) && ((state == S_IDLE) || (state == S_DONE));

    // Resolve the current bit from the comparator and raise the next trial bit.
    always_comb begin
        trial = code_q;
        if (!cmp_s) trial[bit_idx] = 1'b0;
        if (bit_idx != '0) trial[bit_idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= '0;
            result_q <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        code_q  <= MSB;
                        bit_idx <= TOP;
                        cnt     <= RELOAD;
                    end
                end
                S_SETTLE: begin
                    if (bus.abort)      code_q <= '0;
                    else if (cnt != '0) cnt    <= cnt - 1'b1;
                end
                S_DECIDE: begin
                    if (bus.abort) begin
                        code_q <= '0;
                    end else begin
                        code_q <= trial;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - 1'b1;
                            cnt     <= RELOAD;
                        end else begin
                            result_q <= trial;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dac_code = code_q;
    assign bus.result   = result_q;
endmodule

// File: tb/tb_opamp_sar_ctrl.sv
// Bench for opamp_sar_ctrl: comparator model on the DAC code, scoreboard of
// expected results and done edges, directed abort/reset/back-to-back cases.
module tb_opamp_sar_ctrl;
    logic clk;
    logic rst;

    opamp_sar_ctrl_if #(.WIDTH(8)) bus ();

    opamp_sar_ctrl #(.WIDTH(8), .SETTLE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: comparator tied low, 1: tied high, 2: cmp_in = (dac_code <= thr)
    int         cmp_mode = 0;
    logic [7:0] thr = 8'h00;
    assign bus.cmp_in = (cmp_mode == 2) ? (bus.dac_code <= thr) : (cmp_mode == 1);

    logic [7:0]  exp_q[$];
    int unsigned exp_cyc_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                check_eq("result", {24'd0, bus.result}, {24'd0, exp_q.pop_front()});
                check_eq("done_edge", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Start is sampled on the edge that ends with cyc == s.
    task automatic start_pulse(input bit push, input logic [7:0] expv, output int unsigned s);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        s = cyc;
        if (push) begin
            exp_q.push_back(expv);
            exp_cyc_q.push_back(s + 40);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_dac"},    {24'd0, bus.dac_code}, 32'd0);
        check_eq({tag, "_result"}, {24'd0, bus.result},   32'd0);
        check_eq({tag, "_busy"},   {31'd0, bus.busy},     32'd0);
        check_eq({tag, "_done"},   {31'd0, bus.done},     32'd0);
        check_eq({tag, "_state"},  {30'd0, bus.fsm_state}, 32'd0);
    endtask

    logic [7:0] seq [8];
    int unsigned s;

    initial begin
        seq[0] = 8'h80; seq[1] = 8'hC0; seq[2] = 8'hA0; seq[3] = 8'hB0;
        seq[4] = 8'hA8; seq[5] = 8'hA4; seq[6] = 8'hA6; seq[7] = 8'hA5;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Binary search toward 0xA5 with the trial sequence checked
        cmp_mode = 2;
        thr = 8'hA5;
        start_pulse(1'b1, 8'hA5, s);
        for (int k = 0; k < 8; k++) begin
            wait_until(s + 5 * k);
            check_eq($sformatf("dac_seq%0d", k), {24'd0, bus.dac_code}, {24'd0, seq[k]});
            if (k > 0) check_eq($sformatf("busy_seq%0d", k), {31'd0, bus.busy}, 32'd1);
        end
        drain(60);
        @(negedge clk);
        check_eq("busy_after_done", {31'd0, bus.busy}, 32'd0);
        check_eq("dac_after_done", {24'd0, bus.dac_code}, 32'h0000_00A5);

        // Comparator tied low and high
        cmp_mode = 0;
        start_pulse(1'b1, 8'h00, s);
        drain(60);
        cmp_mode = 1;
        start_pulse(1'b1, 8'hFF, s);
        drain(60);
        repeat (5) @(negedge clk);

        // Starts during a conversion are ignored
        cmp_mode = 2;
        thr = 8'hA5;
        start_pulse(1'b1, 8'hA5, s);
        wait_until(s + 9);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(s + 38);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain(60);
        repeat (50) @(negedge clk);
        check_eq("no_restart_busy", {31'd0, bus.busy}, 32'd0);

        // Abort on edge 17 keeps the previous result
        thr = 8'h3C;
        start_pulse(1'b0, 8'h00, s);
        wait_until(s + 16);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("abort_dac",    {24'd0, bus.dac_code}, 32'd0);
        check_eq("abort_busy",   {31'd0, bus.busy},     32'd0);
        check_eq("abort_done",   {31'd0, bus.done},     32'd0);
        check_eq("abort_result", {24'd0, bus.result},   32'h0000_00A5);
        repeat (50) @(negedge clk);
        check_eq("abort_result_later", {24'd0, bus.result}, 32'h0000_00A5);

        // Abort together with start in IDLE does not launch
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq("abort_start_busy", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset mid-SETTLE, then a clean conversion
        thr = 8'h5A;
        start_pulse(1'b0, 8'h00, s);
        wait_until(s + 2);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        start_pulse(1'b1, 8'h5A, s);
        drain(60);
        repeat (3) @(negedge clk);

        // Start held high: back-to-back conversions 41 edges apart
        thr = 8'h3C;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        s = cyc;
        exp_q.push_back(8'h3C);
        exp_cyc_q.push_back(s + 40);
        exp_q.push_back(8'h3C);
        exp_cyc_q.push_back(s + 81);
        wait_until(s + 41);
        bus.start = 1'b0;
        drain(100);
        repeat (5) @(negedge clk);
        check_eq("final_busy", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
